// File: rtl/timed_queue.sv
// Circular FIFO that tags every entry with the number of enabled edges it has waited.
// Optional build macro TIMED_QUEUE_DROP_OLDEST_EN: a push to a full queue evicts the head.
module timed_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int AGE_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic                       pop,
  input  logic signed [DATA_W-1:0]   data,
  output logic                       push_valid,
  output logic                       pop_valid,
  output logic signed [DATA_W-1:0]   out,
  output logic [AGE_W-1:0]           waited,
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
  output logic                       dropped,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1'b1);
  localparam logic [AGE_W-1:0] AGE_ZERO = {AGE_W{1'b0}};
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  // Saturating age increment
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    if (age == AGE_MAX) begin
      return age;
    end else begin
      return age + AGE_ONE;
    end
  endfunction

  logic signed [DATA_W-1:0] mem_r [DEPTH];
  logic [AGE_W-1:0]         age_r [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic                     push_valid_r;
  logic                     pop_valid_r;
  logic signed [DATA_W-1:0] out_r;
  logic [AGE_W-1:0]         waited_r;
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
  logic                     dropped_r;
`endif

  logic                     full_s;
  logic                     empty_s;
  logic                     pop_acc_s;
  logic                     push_acc_s;
  logic                     drop_s;
  logic                     rd_adv_s;
  logic [CNT_W-1:0]         count_nxt_s;
  logic [PTR_W-1:0]         off_s [DEPTH];
  logic                     occ_s [DEPTH];

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // Accept decisions for the current edge
  always_comb begin
    pop_acc_s  = 1'b0;
    push_acc_s = 1'b0;
    drop_s     = 1'b0;
    if (pop && !empty_s) begin
      pop_acc_s = 1'b1;
    end else begin
      pop_acc_s = 1'b0;
    end
    if (push && (!full_s || pop_acc_s)) begin
      push_acc_s = 1'b1;
    end
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
    else if (push) begin
      // full with no pop: evict the head so the new entry fits
      push_acc_s = 1'b1;
      drop_s     = 1'b1;
    end
`endif
    else begin
      push_acc_s = 1'b0;
    end
  end

  // Read pointer movement and next occupancy
  always_comb begin
    rd_adv_s    = pop_acc_s || drop_s;
    count_nxt_s = count_r;
    if (push_acc_s && !rd_adv_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_acc_s && rd_adv_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Slot i is occupied when its distance from the head is below the occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off_s[i] = PTR_W'(i) - rd_ptr_r;
      occ_s[i] = ({1'b0, off_s[i]} < count_r);
    end
  end

  // Payload storage; occupancy gates every read so no reset is needed
  always_ff @(posedge clk) begin
    if (rst && en && push_acc_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (en) begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Per-entry wait counters; a freshly written slot restarts at zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= AGE_ZERO;
      end
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_acc_s && (PTR_W'(i) == wr_ptr_r)) begin
          age_r[i] <= AGE_ZERO;
        end else if (occ_s[i]) begin
          age_r[i] <= age_inc(age_r[i]);
        end
      end
    end
  end

  // Registered result pulses and popped payload
  always_ff @(posedge clk) begin
    if (!rst) begin
      push_valid_r <= 1'b0;
      pop_valid_r  <= 1'b0;
      out_r        <= {DATA_W{1'b0}};
      waited_r     <= AGE_ZERO;
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
      dropped_r    <= 1'b0;
`endif
    end else if (en) begin
      push_valid_r <= push_acc_s;
      pop_valid_r  <= pop_acc_s;
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
      dropped_r    <= drop_s;
`endif
      if (pop_acc_s) begin
        // the pop edge itself counts as one more edge of waiting
        out_r    <= mem_r[rd_ptr_r];
        waited_r <= age_inc(age_r[rd_ptr_r]);
      end
    end
  end

  assign push_valid = push_valid_r;
  assign pop_valid  = pop_valid_r;
  assign out        = out_r;
  assign waited     = waited_r;
  assign count      = count_r;
  assign full       = full_s;
  assign empty      = empty_s;
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
  assign dropped    = dropped_r;
`endif

endmodule

// File: tb/tb_timed_queue.sv
// Scoreboard bench for timed_queue: default instance plus an AGE_W=4 instance for saturation.
module tb_timed_queue;

  typedef struct { logic signed [63:0] d; int t; } ent_t;
  typedef struct { logic signed [63:0] d; logic [15:0] w; } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, push, pop;
  logic signed [63:0] data;
  logic push_valid, pop_valid, full, empty;
  logic signed [63:0] out;
  logic [15:0] waited;
  logic [2:0] count;

  logic en_b, push_b, pop_b;
  logic signed [63:0] data_b;
  logic push_valid_b, pop_valid_b, full_b, empty_b;
  logic signed [63:0] out_b;
  logic [3:0] waited_b;
  logic [2:0] count_b;
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
  logic dropped, dropped_b;
`endif

  timed_queue dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .data(data),
    .push_valid(push_valid), .pop_valid(pop_valid), .out(out), .waited(waited),
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
    .dropped(dropped),
`endif
    .count(count), .full(full), .empty(empty)
  );

  timed_queue #(.DATA_W(64), .DEPTH(4), .AGE_W(4)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .push(push_b), .pop(pop_b), .data(data_b),
    .push_valid(push_valid_b), .pop_valid(pop_valid_b), .out(out_b), .waited(waited_b),
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
    .dropped(dropped_b),
`endif
    .count(count_b), .full(full_b), .empty(empty_b)
  );

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  ent_t sb[$];
  res_t res_q[$];
  logic exp_pv, exp_uv, exp_drop;
  logic signed [63:0] exp_out;
  logic [15:0] exp_wait;

  // Drive one enabled edge on the default instance and update the model
  task automatic edge_a(input logic p, input logic q, input logic signed [63:0] d);
    ent_t e;
    res_t r;
    logic pop_acc, push_acc;
    int w;
    pop_acc  = q && (sb.size() > 0);
    push_acc = p && ((sb.size() < 4) || pop_acc);
    exp_drop = 1'b0;
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
    if (p && !push_acc) begin
      push_acc = 1'b1;
      exp_drop = 1'b1;
      e = sb.pop_front();
    end
`endif
    exp_pv = pop_acc;
    exp_uv = push_acc;
    if (pop_acc) begin
      e = sb.pop_front();
      w = edge_cnt - e.t;
      r.d = e.d;
      r.w = (w > 65535) ? 16'hFFFF : 16'(w);
      res_q.push_back(r);
      exp_out  = r.d;
      exp_wait = r.w;
    end
    if (push_acc) begin
      e.d = d;
      e.t = edge_cnt;
      sb.push_back(e);
    end
    en = 1'b1; push = p; pop = q; data = d;
    @(posedge clk); #1;
    edge_cnt++;
    push = 1'b0; pop = 1'b0;
  endtask

  // Reset both instances for one edge and clear the model
  task automatic apply_reset();
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete(); res_q.delete();
    exp_out = 64'sd0; exp_wait = 16'd0; exp_pv = 1'b0; exp_uv = 1'b0; exp_drop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; push = 1'b1; pop = 1'b1; data = 64'sd5;
    en_b = 1'b1; push_b = 1'b0; pop_b = 1'b0; data_b = 64'sd0;
    repeat (2) @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    sb.delete(); res_q.delete();
    exp_out = 64'sd0; exp_wait = 16'd0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (push_valid !== 1'b0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", push_valid, pop_valid); end
    n_checks++; if (out !== 64'sd0 || waited !== 16'd0) begin n_fail++; $display("FAIL reset_out got=%0d/%0d exp=0/0", out, waited); end
    n_checks++; if (count_b !== 3'd0 || empty_b !== 1'b1) begin n_fail++; $display("FAIL reset_b got=%0d/%b exp=0/1", count_b, empty_b); end
    rst = 1'b1; en = 1'b1;
  endtask

  task automatic test_basic();
    res_t r;
    edge_a(1'b1, 1'b0, 64'sd1);
    n_checks++; if (push_valid !== 1'b1) begin n_fail++; $display("FAIL basic_push_valid got=%b exp=1", push_valid); end
    edge_a(1'b0, 1'b0, 64'sd0);
    n_checks++; if (push_valid !== 1'b0) begin n_fail++; $display("FAIL basic_push_pulse got=%b exp=0", push_valid); end
    edge_a(1'b1, 1'b0, 64'sd2); edge_a(1'b0, 1'b0, 64'sd0);
    edge_a(1'b1, 1'b0, 64'sd3); edge_a(1'b0, 1'b0, 64'sd0);
    edge_a(1'b1, 1'b0, 64'sd4); edge_a(1'b0, 1'b0, 64'sd0);
    edge_a(1'b0, 1'b1, 64'sd0);
    if (res_q.size() > 0) r = res_q.pop_front();
    n_checks++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pop_valid got=%b exp=1", pop_valid); end
    n_checks++; if (out !== 64'sd1) begin n_fail++; $display("FAIL basic_out got=%0d exp=1", out); end
    n_checks++; if (waited !== 16'd8) begin n_fail++; $display("FAIL basic_waited got=%0d exp=8", waited); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", count); end
    edge_a(1'b0, 1'b1, 64'sd0);
    if (res_q.size() > 0) r = res_q.pop_front();
    n_checks++; if (out !== 64'sd2 || waited !== 16'd7) begin n_fail++; $display("FAIL basic_second got=%0d/%0d exp=2/7", out, waited); end
    apply_reset();
  endtask

  task automatic test_full();
    res_t r;
    for (int k = 1; k <= 4; k++) edge_a(1'b1, 1'b0, 64'(k));
    n_checks++; if (count !== 3'd4 || full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL full_flags got=%0d/%b/%b exp=4/1/0", count, full, empty); end
    edge_a(1'b1, 1'b0, 64'sd5);
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
    n_checks++; if (push_valid !== 1'b1 || dropped !== 1'b1) begin n_fail++; $display("FAIL full_drop got=%b/%b exp=1/1", push_valid, dropped); end
    n_checks++; if (pop_valid !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_drop_state got=%b/%0d exp=0/4", pop_valid, count); end
`else
    n_checks++; if (push_valid !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_reject got=%b/%0d exp=0/4", push_valid, count); end
`endif
    edge_a(1'b0, 1'b1, 64'sd0);
    if (res_q.size() > 0) r = res_q.pop_front();
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
    n_checks++; if (pop_valid !== 1'b1 || out !== 64'sd2) begin n_fail++; $display("FAIL full_pop_after_drop got=%b/%0d exp=1/2", pop_valid, out); end
`else
    n_checks++; if (pop_valid !== 1'b1 || out !== 64'sd1) begin n_fail++; $display("FAIL full_pop_after_reject got=%b/%0d exp=1/1", pop_valid, out); end
`endif
    apply_reset();
  endtask

  task automatic test_same_edge();
    res_t r;
    edge_a(1'b1, 1'b1, 64'sd7);
    n_checks++; if (pop_valid !== 1'b0 || push_valid !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL same_edge got=%b/%b/%0d exp=0/1/1", pop_valid, push_valid, count); end
    edge_a(1'b0, 1'b0, 64'sd0); edge_a(1'b0, 1'b0, 64'sd0);
    edge_a(1'b0, 1'b1, 64'sd0);
    if (res_q.size() > 0) r = res_q.pop_front();
    n_checks++; if (pop_valid !== 1'b1 || out !== 64'sd7 || waited !== 16'd3) begin n_fail++; $display("FAIL same_edge_pop got=%b/%0d/%0d exp=1/7/3", pop_valid, out, waited); end
    edge_a(1'b0, 1'b1, 64'sd0);
    n_checks++; if (pop_valid !== 1'b0 || out !== 64'sd7 || waited !== 16'd3 || count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_hold got=%b/%0d/%0d/%0d exp=0/7/3/0", pop_valid, out, waited, count); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    for (int k = 0; k < 4; k++) edge_a(1'b1, 1'b0, 64'(40 + k));
    edge_a(1'b1, 1'b1, -64'sd100);
    if (res_q.size() > 0) r = res_q.pop_front();
    n_checks++; if (count !== 3'd4 || push_valid !== 1'b1 || pop_valid !== 1'b1 || out !== 64'sd40) begin n_fail++; $display("FAIL b2b_full got=%0d/%b/%b/%0d exp=4/1/1/40", count, push_valid, pop_valid, out); end
    for (int i = 0; i < 60; i++) begin
      edge_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $signed({$urandom, $urandom}));
      n_checks++; if (push_valid !== exp_uv || pop_valid !== exp_pv) begin n_fail++; $display("FAIL rand_pulses[%0d] got=%b%b exp=%b%b", i, push_valid, pop_valid, exp_uv, exp_pv); end
      n_checks++; if (count !== 3'(sb.size()) || full !== (sb.size() == 4) || empty !== (sb.size() == 0)) begin n_fail++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count, sb.size()); end
`ifdef TIMED_QUEUE_DROP_OLDEST_EN
      n_checks++; if (dropped !== exp_drop) begin n_fail++; $display("FAIL rand_dropped[%0d] got=%b exp=%b", i, dropped, exp_drop); end
`endif
      if (pop_valid === 1'b1) begin
        n_checks++;
        if (res_q.size() == 0) begin n_fail++; $display("FAIL rand_unexpected_pop[%0d] got=1 exp=0", i); end
        else begin
          r = res_q.pop_front();
          if (out !== r.d || waited !== r.w) begin n_fail++; $display("FAIL rand_pop[%0d] got=%0d/%0d exp=%0d/%0d", i, out, waited, r.d, r.w); end
        end
      end else begin
        n_checks++; if (out !== exp_out || waited !== exp_wait) begin n_fail++; $display("FAIL rand_hold[%0d] got=%0d/%0d exp=%0d/%0d", i, out, waited, exp_out, exp_wait); end
      end
    end
    apply_reset();
  endtask

  task automatic test_enable();
    res_t r;
    edge_a(1'b1, 1'b0, 64'sd11);
    en = 1'b0; push = 1'b1; pop = 1'b1; data = 64'sd99;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (push_valid !== 1'b1 || pop_valid !== 1'b0 || count !== 3'd1 || out !== exp_out || waited !== exp_wait) begin
        n_fail++; $display("FAIL enable_hold[%0d] got=%b/%b/%0d/%0d/%0d exp=1/0/1/%0d/%0d", c, push_valid, pop_valid, count, out, waited, exp_out, exp_wait);
      end
    end
    push = 1'b0; pop = 1'b0;
    edge_a(1'b0, 1'b0, 64'sd0);
    edge_a(1'b0, 1'b1, 64'sd0);
    if (res_q.size() > 0) r = res_q.pop_front();
    n_checks++; if (pop_valid !== 1'b1 || out !== 64'sd11 || waited !== 16'd2) begin n_fail++; $display("FAIL enable_pop got=%b/%0d/%0d exp=1/11/2", pop_valid, out, waited); end
  endtask

  task automatic test_rst_mid();
    edge_a(1'b1, 1'b0, 64'sd21); edge_a(1'b1, 1'b0, 64'sd22); edge_a(1'b1, 1'b0, 64'sd23);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre got=%0d exp=3", count); end
    rst = 1'b0; en = 1'b1; push = 1'b1; pop = 1'b1; data = 64'sd30;
    @(posedge clk); #1;
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    sb.delete(); res_q.delete(); exp_out = 64'sd0; exp_wait = 16'd0;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rstmid_count got=%0d/%b exp=0/1", count, empty); end
    n_checks++; if (push_valid !== 1'b0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses got=%b%b exp=00", push_valid, pop_valid); end
    edge_a(1'b0, 1'b1, 64'sd0);
    n_checks++; if (pop_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rstmid_pop got=%b/%0d exp=0/0", pop_valid, count); end
  endtask

  task automatic test_saturate();
    en = 1'b0;
    push_b = 1'b1; data_b = 64'sd9;
    @(posedge clk); #1;
    push_b = 1'b0;
    n_checks++; if (push_valid_b !== 1'b1 || count_b !== 3'd1) begin n_fail++; $display("FAIL sat_push got=%b/%0d exp=1/1", push_valid_b, count_b); end
    repeat (20) @(posedge clk);
    #1;
    pop_b = 1'b1;
    @(posedge clk); #1;
    pop_b = 1'b0;
    n_checks++; if (pop_valid_b !== 1'b1 || out_b !== 64'sd9 || waited_b !== 4'd15) begin n_fail++; $display("FAIL sat_pop got=%b/%0d/%0d exp=1/9/15", pop_valid_b, out_b, waited_b); end
    n_checks++; if (count_b !== 3'd0 || empty_b !== 1'b1) begin n_fail++; $display("FAIL sat_empty got=%0d/%b exp=0/1", count_b, empty_b); end
    en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_same_edge();
    test_back_to_back();
    test_enable();
    test_rst_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
